// File: rtl/router_input_fifo.sv
// Per-input-port flit buffer for the 5-port mesh router.
// RTS/CTS write side, any-grant pop, first-word fall-through head.
module router_input_fifo #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  DRTS,
  input  logic [DATA_WIDTH-1:0] RX,
  output logic                  CTS,
  input  logic                  read_en_N,
  input  logic                  read_en_E,
  input  logic                  read_en_W,
  input  logic                  read_en_S,
  input  logic                  read_en_L,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_WIDTH:0]    count,
  output logic                  err_multi_read
);

  localparam int CW = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_cts;
  logic                  r_err;

  logic [4:0] w_rd_vec;
  logic       w_rd_any;
  logic       w_multi;
  logic       w_wr;
  logic       w_rd;
  logic       w_empty;
  logic       w_full;

  assign w_rd_vec = {read_en_N, read_en_E, read_en_W,
                     read_en_S, read_en_L};
  assign w_rd_any = |w_rd_vec;
  // Clearing the lowest set bit leaves a remainder only if 2+ bits were set
  assign w_multi  = |(w_rd_vec & (w_rd_vec - 5'd1));

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  assign w_wr = DRTS & ~r_cts & ~w_full;
  assign w_rd = w_rd_any & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_cts    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cts <= w_wr;
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_multi)
        r_err <= 1'b1;
    end
  end

  // Storage is intentionally left uninitialised by reset
  always_ff @(posedge clk) begin
    if (!rst && w_wr)
      r_mem[r_wr_ptr] <= RX;
  end

  assign Data_out       = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty          = w_empty;
  assign full           = w_full;
  assign count          = r_count;
  assign CTS            = r_cts;
  assign err_multi_read = r_err;

endmodule
